instr_sequencer: RTL and testbench

//  Program loader and sequencer that sits directly upstream of the autoencoder datapath and feeds it 16-bit instructions.
//  - Format: (opcode)(field1)(field2)(field3), 4 bits each.
//  - Replaces the free-running fetch counter with a controlled sequence: a host loads a program, pulses start, then gets done.
//  - Instructions are issued one per cycle under a stall handshake.
//  - The sequence ends on a HALT opcode or at the end of the program.

---
 rtl/instr_sequencer_pkg.sv | 18 +
 rtl/instr_seq_ram.sv | 31 +++
 rtl/instr_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode values, default widths and
// FSM state encoding. Imported by instr_sequencer.
package instr_sequencer_pkg;

  localparam int unsigned SeqAddrW = 5;
  localparam int unsigned SeqDataW = 16;

  localparam logic [3:0] HaltOpcode = 4'hF;
  localparam logic [3:0] LoopOpcode = 4'hE;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/instr_seq_ram.sv
// Program store for the instruction sequencer: 2**ADDR_W x DATA_W words, synchronous write,
// synchronous (registered) read. Contents are not reset.
// Ports:
//   clock    in   rising-edge clock
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  word at rd_addr from the previous cycle
module instr_seq_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program loader and sequencer feeding 16-bit instructions (opcode|f1|f2|f3) to the datapath.
// A host streams a program in (load_valid/load_ready/load_last), pulses start, and the
// sequencer issues one word per cycle under a stall handshake until a HALT opcode or the end
// of the program, then pulses done. The word after the presented one is always prefetched from
// the RAM so the end of the sequence is known at hand-off time.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   load_valid/ready/data/last  program load stream
//   start                   1-cycle pulse, run from address 0
//   stall                   datapath not ready, hold presented word
//   instr_out/instr_valid/pc    issued instruction, valid flag and its address
//   busy                    high while loading or running
//   done                    1-cycle pulse at the end of a run
// Build option: define SEQ_LOOP_EN to make opcode 4'hE a single-level LOOP consumed internally.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = SeqAddrW,
  parameter int unsigned DATA_W      = SeqDataW,
  parameter logic [3:0]  HALT_OPCODE = HaltOpcode
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              stall,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  seq_state_e state_q, state_d;

  logic [ADDR_W:0]   wr_ptr_q, prog_len_q;
  logic [ADDR_W:0]   fetch_q;     // address of the word currently on rd_data
  logic [ADDR_W:0]   fetch_nxt;
  logic              full_q;      // last load filled the RAM; blocks beats until valid drops
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  logic              we;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              accept, start_ok, take, at_top, load_end, fetch_end;
  logic              is_loop, loop_jump;
  logic [3:0]        fetch_op;

  instr_seq_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign accept    = load_valid & load_ready;
  assign start_ok  = (state_q == StIdle) & start & (prog_len_q != '0);
  // Output register can take a new word: empty, or current word handed off this cycle.
  assign take      = (state_q == StRun) & (~valid_q | ~stall);
  assign at_top    = (wr_ptr_q[ADDR_W-1:0] == '1);
  assign load_end  = (state_q == StLoad) & accept & (load_last | at_top);
  assign fetch_op  = rd_data[DATA_W-1 -: 4];
  assign fetch_end = (fetch_q >= prog_len_q) | (fetch_op == HALT_OPCODE);

`ifdef SEQ_LOOP_EN
  logic            loop_active_q;
  logic [3:0]      loop_cnt_q;
  logic [ADDR_W:0] loop_addr_q;
  logic            loop_same;
  logic [3:0]      loop_n;

  assign loop_n    = rd_data[DATA_W-5 -: 4];
  assign is_loop   = (fetch_op == LoopOpcode) & ~fetch_end;
  // Re-meeting the active loop's own LOOP word; any other LOOP while active falls through.
  assign loop_same = loop_active_q & (loop_addr_q == fetch_q);
  // cnt==1 on a re-encounter means this decrement reaches zero: fall through.
  assign loop_jump = is_loop & (loop_same ? (loop_cnt_q != 4'd1)
                                          : (~loop_active_q & (loop_n != 4'd0)));
  assign fetch_nxt = loop_jump ? {1'b0, rd_data[ADDR_W-1:0]} : fetch_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      loop_addr_q   <= '0;
    end else if (start_ok) begin
      loop_active_q <= 1'b0;
    end else if (take & is_loop) begin
      if (loop_jump) begin
        if (loop_same) begin
          loop_cnt_q <= loop_cnt_q - 1'b1;
        end else begin
          loop_active_q <= 1'b1;
          loop_cnt_q    <= loop_n;
          loop_addr_q   <= fetch_q;
        end
      end else if (loop_same) begin
        loop_active_q <= 1'b0;
      end
    end
  end
`else
  assign is_loop   = 1'b0;
  assign loop_jump = 1'b0;
  assign fetch_nxt = fetch_q + 1'b1;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start wins over a simultaneous load beat in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
        end else if (accept & ~load_last) begin
          state_d = StLoad;
        end
      end
      StLoad:  if (load_end) state_d = StIdle;
      StRun:   if (take & fetch_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and RAM control
  always_comb begin
    load_ready = ((state_q == StIdle) & ~start & ~full_q) | (state_q == StLoad);
    busy       = (state_q == StLoad) | (state_q == StRun);
    done       = (state_q == StDone);
    we         = accept;
    wr_addr    = (state_q == StLoad) ? wr_ptr_q[ADDR_W-1:0] : '0;
    rd_addr    = '0;
    if (state_q == StRun) begin
      rd_addr = (take & ~fetch_end) ? fetch_nxt[ADDR_W-1:0] : fetch_q[ADDR_W-1:0];
    end
  end

  // Load pointers and issue pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      fetch_q    <= '0;
      full_q     <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            fetch_q <= '0;
            full_q  <= 1'b0;
          end else if (accept) begin
            wr_ptr_q <= (ADDR_W+1)'(1);
            if (load_last) prog_len_q <= (ADDR_W+1)'(1);
          end else if (!load_valid) begin
            full_q <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load_end) begin
              prog_len_q <= wr_ptr_q + 1'b1;
              full_q     <= at_top & ~load_last;
            end
          end
        end
        StRun: begin
          if (take) begin
            if (fetch_end) begin
              valid_q <= 1'b0;
            end else if (is_loop) begin
              valid_q <= 1'b0;
              fetch_q <= fetch_nxt;
            end else begin
              instr_q <= rd_data;
              pc_q    <= fetch_q[ADDR_W-1:0];
              valid_q <= 1'b1;
              fetch_q <= fetch_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Expected issue sequences come from a program-walking
// reference model; stimulus mixes directed programs with random programs and random stalls.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  instr_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .start       (start),
    .stall       (stall),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prog [32];
  int          plen_m = 0;
  int          exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Walk the program as the host would read it: issue until HALT or end of program.
  function automatic void build_exp();
    int          addr;
    int          steps;
    logic [15:0] w;
`ifdef SEQ_LOOP_EN
    bit          lp_act;
    int          lp_at;
    int          lp_rem;
    lp_act = 1'b0;
    lp_at  = 0;
    lp_rem = 0;
`endif
    addr  = 0;
    steps = 0;
    exp_q.delete();
    while (addr < plen_m && steps < 2000) begin
      steps++;
      w = prog[addr];
      if (w[15:12] == 4'hF) break;
`ifdef SEQ_LOOP_EN
      if (w[15:12] == 4'hE) begin
        if (lp_act && addr == lp_at) begin
          lp_rem--;
          if (lp_rem > 0) addr = int'(w[4:0]);
          else begin
            lp_act = 1'b0;
            addr++;
          end
        end else if (!lp_act && w[11:8] != 4'd0) begin
          lp_act = 1'b1;
          lp_at  = addr;
          lp_rem = int'(w[11:8]);
          addr   = int'(w[4:0]);
        end else begin
          addr++;
        end
        continue;
      end
`endif
      exp_q.push_back((addr << 16) | int'(w));
      addr++;
    end
  endfunction

  task automatic gen_prog(input int n, input bit with_halt);
    for (int i = 0; i < n; i++) begin
      logic [11:0] lo;
      logic [3:0]  op;
      lo = 12'($urandom);
      op = 4'($urandom_range(0, 13));
      prog[i] = {op, lo};
    end
    if (with_halt) prog[$urandom_range(0, n - 1)] = 16'hF000 | 16'($urandom_range(0, 4095));
  endtask

  task automatic load_words(input int n, input bit use_last, input bit extra);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == n - 1);
      @(negedge clock);
      check("load_ready", {31'b0, load_ready}, 32'd1);
    end
    @(posedge clock); #1;
    load_last = 1'b0;
    if (extra) begin
      load_data = 16'h1234;
      @(negedge clock);
      check("load_ready_full", {31'b0, load_ready}, 32'd0);
      @(posedge clock); #1;
    end
    load_valid = 1'b0;
    plen_m = n;
  endtask

  // mode 0: no stall, 1: random stall, 2: stall 4 cycles while 16'h2456 is presented
  task automatic run_prog(input string name, input int mode, input bit strict, output int n_iss);
    int          issued[$];
    int          k, first_k, last_k, done_k, done_cnt, stall_left, n_cmp;
    bit          hold;
    logic [15:0] h_instr;
    logic [4:0]  h_pc;
    first_k = -1; last_k = -1; done_k = -1; done_cnt = 0; stall_left = 4; hold = 1'b0;
    h_instr = '0; h_pc = '0;
    build_exp();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    k = 1;
    while (k <= 400 && !(done_cnt > 0 && k > done_k + 3)) begin
      if (mode == 1) stall = ($urandom_range(0, 1) == 1);
      else if (mode == 2) begin
        stall = instr_valid && (instr_out == 16'h2456) && (stall_left > 0);
        if (stall) stall_left--;
      end else stall = 1'b0;
      @(negedge clock);
      if (hold) begin
        check({name, "/hold_instr"}, {16'b0, instr_out}, {16'b0, h_instr});
        check({name, "/hold_pc"}, {27'b0, pc}, {27'b0, h_pc});
        check({name, "/hold_valid"}, {31'b0, instr_valid}, 32'd1);
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end else if (done_cnt == 0) begin
        check({name, "/busy_run"}, {31'b0, busy}, 32'd1);
      end
      if (instr_valid) begin
        if (first_k < 0) first_k = k;
        if (!stall) begin
          issued.push_back(int'({pc, instr_out}));
          last_k = k;
        end
      end
      hold    = instr_valid && stall;
      h_instr = instr_out;
      h_pc    = pc;
      @(posedge clock); #1;
      k++;
    end
    stall = 1'b0;
    check({name, "/done_pulses"}, done_cnt, 1);
    check({name, "/issued_count"}, issued.size(), exp_q.size());
    n_cmp = (issued.size() < exp_q.size()) ? issued.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) check({name, "/issue"}, issued[i], exp_q[i]);
    if (strict) begin
      if (exp_q.size() > 0) begin
        check({name, "/first_latency"}, first_k, 2);
        check({name, "/done_after_last"}, done_k, last_k + 1);
      end else begin
        check({name, "/done_empty"}, done_k, 2);
      end
    end
    check({name, "/busy_end"}, {31'b0, busy}, 32'd0);
    n_iss = issued.size();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_iss;
    int  n;
    bit  found;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset/instr_out", {16'b0, instr_out}, 32'd0);
    check("reset/ctrl", {28'b0, instr_valid, busy, done, load_ready}, 32'b0001);
    check("reset/pc", {27'b0, pc}, 32'd0);
    reset_n = 1'b1;

    // start with no program: ignored
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("empty_start", {29'b0, busy, done, instr_valid}, 32'd0);
    end

    // Basic three-word program, then rerun, then a long stall on the second word
    prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'h3789;
    load_words(3, 1'b1, 1'b0);
    run_prog("t1", 0, 1'b1, n_iss);
    run_prog("t1_rerun", 1, 1'b1, n_iss);
    run_prog("t2_stall", 2, 1'b1, n_iss);

    // HALT in the middle
    prog[0] = 16'h1000; prog[1] = 16'hF000; prog[2] = 16'h2000;
    load_words(3, 1'b1, 1'b0);
    run_prog("t3_halt", 1, 1'b1, n_iss);
    check("t3_count", n_iss, 1);

    // Single-beat program
    prog[0] = 16'h4321;
    load_words(1, 1'b1, 1'b0);
    run_prog("one_word", 0, 1'b1, n_iss);

    // LOOP opcode (or ordinary word when looping is not built)
    prog[0] = 16'h1AAA; prog[1] = 16'h2BBB; prog[2] = 16'hE201; prog[3] = 16'h3CCC;
    load_words(4, 1'b1, 1'b0);
`ifdef SEQ_LOOP_EN
    run_prog("t6_loop", 1, 1'b0, n_iss);
    check("t6_count", n_iss, 5);
`else
    run_prog("t6_loop", 1, 1'b1, n_iss);
    check("t6_count", n_iss, 4);
`endif

    // Fill the RAM without load_last; 33rd beat refused
    gen_prog(32, 1'b0);
    load_words(32, 1'b0, 1'b1);
    run_prog("t4_full", 1, 1'b1, n_iss);
    check("t4_count", n_iss, 32);

    // Random programs with random stalls
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 32);
      gen_prog(n, $urandom_range(0, 2) == 0);
      load_words(n, (n < 32) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
      run_prog("rand", 1, 1'b1, n_iss);
    end

    // Reset in the middle of a run
    gen_prog(5, 1'b0);
    load_words(5, 1'b1, 1'b0);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (instr_valid && pc == 5'd2) found = 1'b1;
    end
    check("t5/reach_pc2", {31'b0, found}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5/async_instr", {16'b0, instr_out}, 32'd0);
    check("t5/async_ctrl", {29'b0, instr_valid, busy, done}, 32'd0);
    check("t5/async_pc", {27'b0, pc}, 32'd0);
    @(negedge clock);
    check("t5/no_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    plen_m = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t5/start_ignored", {29'b0, busy, done, instr_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
